// File: rtl/piece_rng.sv
// Piece randomiser: free-running Galois LFSR feeding a uniform/bag piece selector
// with a valid/ready output port and bounded-latency fallback selection.
module piece_rng #(
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED       = 16'h0001,
  parameter int                NUM_PIECES = 7,
  parameter int                PIECE_W    = 3,
  parameter int                MAX_TRIES  = 15
) (
  input  logic                  clka,
  input  logic                  restart,
  input  logic                  mode,
  input  logic                  entropy_in,
  input  logic                  piece_ready,
  output logic [PIECE_W-1:0]    piece,
  output logic                  piece_valid,
  output logic                  bag_done,
  output logic [NUM_PIECES-1:0] used_mask,
  output logic                  state_dbg
);

  // Handshake: a piece transfers on any rising edge where piece_valid && piece_ready;
  // piece and piece_valid never change while valid is high and ready is low.

  localparam int TRY_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

  typedef enum logic {SEARCH = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LFSR_W-1:0]       lfsr_q, lfsr_step, lfsr_d;
  logic [TRY_W-1:0]        try_cnt_q, try_cnt_d;
  logic                    mode_q;
  logic [PIECE_W-1:0]      cand, fb_idx, sel, piece_d;
  logic [NUM_PIECES-1:0]   eff_mask, sel_mask, used_mask_d;
  logic [2**PIECE_W-1:0]   free_vec;
  logic                    cand_ok, try_hit, select, valid_d, bag_done_d;

  assign state_dbg = state_q;

  // All-zero is a lock-up state for the LFSR, so it is replaced by the seed.
  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0) ^ {entropy_in, {(LFSR_W-1){1'b0}}};
    lfsr_d    = (lfsr_step == '0) ? SEED : lfsr_step;
  end

  // A mode change wipes the bag so a same-cycle selection sees an empty mask.
  always_comb begin
    eff_mask = (mode != mode_q) ? '0 : used_mask;
    free_vec = '0;
    for (int i = 0; i < NUM_PIECES; i++) free_vec[i] = !mode || !eff_mask[i];
    fb_idx = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) if (free_vec[i]) fb_idx = PIECE_W'(i);
    cand    = lfsr_q[PIECE_W-1:0];
    cand_ok = free_vec[cand];
    try_hit = (try_cnt_q == TRY_W'(MAX_TRIES));
    select  = (state_q == SEARCH) && (cand_ok || try_hit);
    sel     = cand_ok ? cand : fb_idx;
    sel_mask = eff_mask;
    for (int i = 0; i < NUM_PIECES; i++) if (PIECE_W'(i) == sel) sel_mask[i] = 1'b1;
  end

  always_ff @(posedge clka) begin
    if (restart) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (select) state_d = HOLD;
      HOLD:    if (piece_ready) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    piece_d     = piece;
    valid_d     = piece_valid;
    try_cnt_d   = try_cnt_q;
    used_mask_d = mode ? eff_mask : '0;
    bag_done_d  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (select) begin
          piece_d   = sel;
          valid_d   = 1'b1;
          try_cnt_d = '0;
          if (mode) begin
            if (&sel_mask) begin
              used_mask_d = '0;
              bag_done_d  = 1'b1;
            end else begin
              used_mask_d = sel_mask;
            end
          end
        end else begin
          try_cnt_d = try_cnt_q + 1'b1;
        end
      end
      HOLD:    if (piece_ready) valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      lfsr_q      <= SEED;
      piece       <= '0;
      piece_valid <= 1'b0;
      bag_done    <= 1'b0;
      used_mask   <= '0;
      try_cnt_q   <= '0;
      mode_q      <= mode;
    end else begin
      lfsr_q      <= lfsr_d;
      piece       <= piece_d;
      piece_valid <= valid_d;
      bag_done    <= bag_done_d;
      used_mask   <= used_mask_d;
      try_cnt_q   <= try_cnt_d;
      mode_q      <= mode;
    end
  end

endmodule

// File: tb/tb_piece_rng.sv
// Directed bench for piece_rng: reset/first draw, LFSR sequence and zero guard,
// bag permutations, fallback selection, mode switch and restart during HOLD.
module tb_piece_rng;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  // main instance (default parameters)
  logic       restart = 1'b1, mode = 1'b0, entropy_in = 1'b0, piece_ready = 1'b0;
  logic [2:0] piece;
  logic       piece_valid, bag_done, state_dbg;
  logic [6:0] used_mask;

  // fallback instance, bag-mode scenario (MAX_TRIES = 0)
  logic       restart_b = 1'b1, mode_b = 1'b1, ent_b = 1'b0, ready_b = 1'b0;
  logic [2:0] piece_b;
  logic       valid_b, bag_done_b, state_dbg_b;
  logic [6:0] used_mask_b;

  // fallback instance, uniform-mode scenario (seed gives cand = 7)
  logic       restart_c = 1'b1, mode_c = 1'b0, ent_c = 1'b0, ready_c = 1'b0;
  logic [2:0] piece_c;
  logic       valid_c, bag_done_c, state_dbg_c;
  logic [6:0] used_mask_c;

  // zero-guard instance (seed 6801 with entropy 1 would step to 0000)
  logic       restart_g = 1'b1, mode_g = 1'b0, ent_g = 1'b0, ready_g = 1'b0;
  logic [2:0] piece_g;
  logic       valid_g, bag_done_g, state_dbg_g;
  logic [6:0] used_mask_g;

  piece_rng dut (
    .clka(clka), .restart(restart), .mode(mode), .entropy_in(entropy_in),
    .piece_ready(piece_ready), .piece(piece), .piece_valid(piece_valid),
    .bag_done(bag_done), .used_mask(used_mask), .state_dbg(state_dbg)
  );

  piece_rng #(.MAX_TRIES(0)) dut_b (
    .clka(clka), .restart(restart_b), .mode(mode_b), .entropy_in(ent_b),
    .piece_ready(ready_b), .piece(piece_b), .piece_valid(valid_b),
    .bag_done(bag_done_b), .used_mask(used_mask_b), .state_dbg(state_dbg_b)
  );

  piece_rng #(.SEED(16'h0007), .MAX_TRIES(0)) dut_c (
    .clka(clka), .restart(restart_c), .mode(mode_c), .entropy_in(ent_c),
    .piece_ready(ready_c), .piece(piece_c), .piece_valid(valid_c),
    .bag_done(bag_done_c), .used_mask(used_mask_c), .state_dbg(state_dbg_c)
  );

  piece_rng #(.SEED(16'h6801)) dut_g (
    .clka(clka), .restart(restart_g), .mode(mode_g), .entropy_in(ent_g),
    .piece_ready(ready_g), .piece(piece_g), .piece_valid(valid_g),
    .bag_done(bag_done_g), .used_mask(used_mask_g), .state_dbg(state_dbg_g)
  );

  logic [15:0] lfsr_tbl [13] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680,
                                 16'h0B40, 16'h05A0, 16'h02D0, 16'h0168, 16'h00B4,
                                 16'h005A, 16'h002D, 16'hB416};
  logic [2:0]  bag0_tbl [7]  = '{3'd1, 3'd0, 3'd4, 3'd5, 3'd3, 3'd2, 3'd6};
  logic [2:0]  exp_q[$];
  logic [2:0]  draws_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int draws;
    int cycles;
    logic [6:0] seen;
    logic [2:0] e;

    // reset and first draw, uniform mode, no consumer
    step();
    check("rst_valid", piece_valid, 0);
    check("rst_piece", piece, 0);
    check("rst_mask", used_mask, 0);
    check("rst_bag_done", bag_done, 0);
    check("rst_state", state_dbg, 0);
    check("rst_lfsr", dut.lfsr_q, 16'h0001);
    restart = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i < 13) check("lfsr_seq", dut.lfsr_q, lfsr_tbl[i]);
      check("first_piece", piece, 1);
      check("first_valid", piece_valid, 1);
    end
    check("uni_mask", used_mask, 0);

    // bag mode, consumer always ready, 21 draws
    restart = 1'b1; mode = 1'b1; piece_ready = 1'b1;
    step();
    restart = 1'b0;
    draws = 0; cycles = 0;
    while (draws < 21 && cycles < 3000) begin
      step();
      cycles++;
      if (piece_valid) begin
        draws++;
        draws_q.push_back(piece);
        check("bag_done_pulse", bag_done, (draws % 7 == 0) ? 1 : 0);
        if (draws % 7 == 0) check("bag_mask_clr", used_mask, 0);
      end else begin
        check("bag_done_idle", bag_done, 0);
      end
    end
    check("bag_draw_count", draws, 21);
    for (int i = 0; i < 7 && i < draws_q.size(); i++) check("bag0_piece", draws_q[i], bag0_tbl[i]);
    for (int g = 0; g < 3; g++) begin
      seen = '0;
      for (int k = 0; k < 7; k++) begin
        if (g * 7 + k < draws_q.size()) begin
          e = draws_q[g * 7 + k];
          if (e < 3'd7) seen[e] = 1'b1;
        end
      end
      check("bag_perm", seen, 7'h7F);
    end

    // mode switch while a piece is held
    restart = 1'b1; mode = 1'b1; piece_ready = 1'b1;
    step();
    restart = 1'b0;
    draws = 0; cycles = 0;
    while (draws < 3 && cycles < 200) begin
      step();
      cycles++;
      if (piece_valid) begin
        draws++;
        if (draws == 3) piece_ready = 1'b0;
      end
    end
    check("ms_draws", draws, 3);
    check("ms_piece3", piece, 4);
    check("ms_mask3", used_mask, 7'b0010011);
    mode = 1'b0;
    step();
    check("ms_mask_uni", used_mask, 0);
    check("ms_piece_uni", piece, 4);
    check("ms_valid_uni", piece_valid, 1);
    mode = 1'b1;
    step();
    check("ms_mask_bag", used_mask, 0);
    check("ms_piece_bag", piece, 4);
    check("ms_valid_bag", piece_valid, 1);

    // restart during HOLD with ready asserted
    piece_ready = 1'b1; restart = 1'b1;
    step();
    check("rh_valid", piece_valid, 0);
    check("rh_piece", piece, 0);
    check("rh_mask", used_mask, 0);
    check("rh_state", state_dbg, 0);
    restart = 1'b0;
    step();
    check("rh_redraw", piece, 1);
    check("rh_revalid", piece_valid, 1);

    // bag fallback with MAX_TRIES = 0: last free piece 6 chosen over cand 3
    exp_q = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    step();
    check("b_rst", {piece_b, valid_b, bag_done_b, used_mask_b, state_dbg_b}, 0);
    restart_b = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      if (cyc >= 2) ready_b = 1'b1;
      if (cyc == 1) check("b_hold_state", state_dbg_b, 1);
      if (cyc == 12) check("b_mask_full6", used_mask_b, 7'b0111111);
      if (valid_b && ready_b) begin
        if (exp_q.size() > 0) check("b_draw", piece_b, exp_q.pop_front());
        else check("b_extra_draw", piece_b, 7);
      end
    end
    check("b_fb_done", bag_done_b, 1);
    check("b_fb_mask", used_mask_b, 0);
    check("b_left", exp_q.size(), 0);

    // uniform fallback: cand 7 is rejected, lowest index 0 is taken
    step();
    check("c_rst", {piece_c, valid_c, bag_done_c, used_mask_c, state_dbg_c}, 0);
    restart_c = 1'b0;
    step();
    check("c_fb_piece", piece_c, 0);
    check("c_fb_valid", valid_c, 1);

    // LFSR zero guard and entropy injection
    step();
    check("g_rst", {piece_g, valid_g, bag_done_g, used_mask_g, state_dbg_g}, 0);
    check("g_seed", dut_g.lfsr_q, 16'h6801);
    restart_g = 1'b0; ent_g = 1'b1;
    step();
    check("g_zero_guard", dut_g.lfsr_q, 16'h6801);
    ent_g = 1'b0;
    step();
    check("g_step", dut_g.lfsr_q, 16'h8000);
    ent_g = 1'b1;
    step();
    check("g_entropy", dut_g.lfsr_q, 16'hC000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
